// File: rtl/nasti_write_arbiter.sv
// Round-robin arbiter sharing one NASTI write port (AW/W/B) between NM masters.
// The grant covers one AW beat plus its W burst; B responses route back by the ID prefix.
module nasti_write_arbiter #(
  parameter int NM         = 2,
  parameter int ID_WIDTH   = 1,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int USER_WIDTH = 1,
  localparam int IW  = (NM > 1) ? $clog2(NM) : 1,
  localparam int SIW = ID_WIDTH + IW,
  localparam int AWP = ADDR_WIDTH + USER_WIDTH + 29,
  localparam int WP  = DATA_WIDTH + DATA_WIDTH / 8 + USER_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NM*ID_WIDTH-1:0]   m_aw_id,
  input  logic [NM*AWP-1:0]        m_aw_pld,
  input  logic [NM-1:0]            m_aw_valid,
  output logic [NM-1:0]            m_aw_ready,
  input  logic [NM*WP-1:0]         m_w_pld,
  input  logic [NM-1:0]            m_w_last,
  input  logic [NM-1:0]            m_w_valid,
  output logic [NM-1:0]            m_w_ready,
  output logic [NM*ID_WIDTH-1:0]   m_b_id,
  output logic [NM*2-1:0]          m_b_resp,
  output logic [NM*USER_WIDTH-1:0] m_b_user,
  output logic [NM-1:0]            m_b_valid,
  input  logic [NM-1:0]            m_b_ready,
  output logic [SIW-1:0]           s_aw_id,
  output logic [AWP-1:0]           s_aw_pld,
  output logic                     s_aw_valid,
  input  logic                     s_aw_ready,
  output logic [WP-1:0]            s_w_pld,
  output logic                     s_w_last,
  output logic                     s_w_valid,
  input  logic                     s_w_ready,
  input  logic [SIW-1:0]           s_b_id,
  input  logic [1:0]               s_b_resp,
  input  logic [USER_WIDTH-1:0]    s_b_user,
  input  logic                     s_b_valid,
  output logic                     s_b_ready
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t        state;
  logic [IW-1:0] grant;
  logic [IW-1:0] ptr;
  logic [IW-1:0] next_grant;
  logic          aw_done;
  logic          w_done;
  logic          busy;
  logic          aw_hs;
  logic          w_last_hs;
  logic          aw_fin;
  logic          w_fin;
  logic [IW-1:0] b_idx;
  logic          b_in_range;

  function automatic logic [IW-1:0] rr_idx(input logic [IW-1:0] p, input int k);
    return IW'((int'(p) + k) % NM);
  endfunction

  // Round-robin pick: scan from farthest to nearest so ptr+1 ends up with top priority
  always_comb begin
    next_grant = grant;
    for (int k = NM; k >= 1; k--) begin
      next_grant = m_aw_valid[rr_idx(ptr, k)] ? rr_idx(ptr, k) : next_grant;
    end
  end

  assign busy      = (state == BUSY);
  assign aw_hs     = busy & m_aw_valid[grant] & ~aw_done & s_aw_ready;
  assign w_last_hs = busy & m_w_valid[grant] & m_w_last[grant] & ~w_done & s_w_ready;
  assign aw_fin    = aw_done | aw_hs;
  assign w_fin     = w_done | w_last_hs;

  // Route the granted master's AW/W to the slave and return readies to it alone
  always_comb begin
    s_aw_id    = {grant, m_aw_id[int'(grant)*ID_WIDTH +: ID_WIDTH]};
    s_aw_pld   = m_aw_pld[int'(grant)*AWP +: AWP];
    s_aw_valid = busy & m_aw_valid[grant] & ~aw_done;
    s_w_pld    = m_w_pld[int'(grant)*WP +: WP];
    s_w_last   = m_w_last[grant];
    s_w_valid  = busy & m_w_valid[grant] & ~w_done;
    m_aw_ready = '0;
    m_w_ready  = '0;
    if (busy) begin
      m_aw_ready[grant] = s_aw_ready & ~aw_done;
      m_w_ready[grant]  = s_w_ready & ~w_done;
    end else begin
      m_aw_ready = '0;
      m_w_ready  = '0;
    end
  end

  assign b_idx      = s_b_id[SIW-1:ID_WIDTH];
  assign b_in_range = (int'(b_idx) < NM);

  // Stateless B return; an out-of-range prefix is swallowed so the slave never stalls
  always_comb begin
    m_b_valid = '0;
    s_b_ready = 1'b1;
    if (b_in_range) begin
      m_b_valid[b_idx] = s_b_valid;
      s_b_ready        = m_b_ready[b_idx];
    end else begin
      m_b_valid = '0;
      s_b_ready = 1'b1;
    end
  end

  assign m_b_id   = {NM{s_b_id[ID_WIDTH-1:0]}};
  assign m_b_resp = {NM{s_b_resp}};
  assign m_b_user = {NM{s_b_user}};

  // Grant FSM: hold the grant until both the AW beat and the last W beat have passed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      grant   <= '0;
      ptr     <= IW'(NM - 1);
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|m_aw_valid) begin
            grant <= next_grant;
            state <= BUSY;
          end else begin
            state <= IDLE;
          end
        end
        BUSY: begin
          if (aw_fin && w_fin) begin
            state   <= IDLE;
            ptr     <= grant;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
          end else begin
            aw_done <= aw_fin;
            w_done  <= w_fin;
          end
        end
        default: begin
          state   <= IDLE;
          aw_done <= 1'b0;
          w_done  <= 1'b0;
        end
      endcase
    end
  end

  b_id_in_range: assert property (@(posedge clk) disable iff (rst) s_b_valid |-> b_in_range);
  grant_stable:  assert property (@(posedge clk) disable iff (rst)
                                  (s_aw_valid || s_w_valid) |=> $stable(grant));

endmodule

// File: tb/tb_nasti_write_arbiter.sv
// Directed self-checking bench for nasti_write_arbiter (NM=2, 1-bit IDs, 8-bit addr/data).
module tb_nasti_write_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  m_aw_id = 2'b10;
  logic [75:0] m_aw_pld;
  logic [1:0]  m_aw_valid, m_aw_ready;
  logic [19:0] m_w_pld;
  logic [1:0]  m_w_last, m_w_valid, m_w_ready;
  logic [1:0]  m_b_id;
  logic [3:0]  m_b_resp;
  logic [1:0]  m_b_user, m_b_valid, m_b_ready;
  logic [1:0]  s_aw_id;
  logic [37:0] s_aw_pld;
  logic        s_aw_valid, s_aw_ready;
  logic [9:0]  s_w_pld;
  logic        s_w_last, s_w_valid, s_w_ready;
  logic [1:0]  s_b_id;
  logic [1:0]  s_b_resp;
  logic [0:0]  s_b_user;
  logic        s_b_valid, s_b_ready;

  int checks = 0;
  int errors = 0;

  nasti_write_arbiter dut (
    .clk(clk), .rst(rst),
    .m_aw_id(m_aw_id), .m_aw_pld(m_aw_pld), .m_aw_valid(m_aw_valid), .m_aw_ready(m_aw_ready),
    .m_w_pld(m_w_pld), .m_w_last(m_w_last), .m_w_valid(m_w_valid), .m_w_ready(m_w_ready),
    .m_b_id(m_b_id), .m_b_resp(m_b_resp), .m_b_user(m_b_user),
    .m_b_valid(m_b_valid), .m_b_ready(m_b_ready),
    .s_aw_id(s_aw_id), .s_aw_pld(s_aw_pld), .s_aw_valid(s_aw_valid), .s_aw_ready(s_aw_ready),
    .s_w_pld(s_w_pld), .s_w_last(s_w_last), .s_w_valid(s_w_valid), .s_w_ready(s_w_ready),
    .s_b_id(s_b_id), .s_b_resp(s_b_resp), .s_b_user(s_b_user),
    .s_b_valid(s_b_valid), .s_b_ready(s_b_ready)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [37:0] awp(input logic [7:0] addr, input logic [7:0] len);
    return {addr, len, 3'd0, 2'd1, 1'b0, 4'd3, 3'd0, 4'd0, 4'd0, 1'b0};
  endfunction

  function automatic logic [9:0] wp(input logic [7:0] data);
    return {data, 1'b1, 1'b0};
  endfunction

  task automatic clear_inputs();
    m_aw_pld = '0; m_aw_valid = '0; m_w_pld = '0; m_w_last = '0; m_w_valid = '0;
    m_b_ready = '0; s_aw_ready = 1'b0; s_w_ready = 1'b0;
    s_b_id = '0; s_b_resp = '0; s_b_user = '0; s_b_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Both masters issue two len=3 bursts each, slave always ready
  task automatic run_alt();
    int left[2], beat[2], nb[2];
    bit act[2], sent[2];
    int naw, nw, k;
    naw = 0;
    nw  = 0;
    for (int m = 0; m < 2; m++) begin
      left[m] = 2; beat[m] = 0; nb[m] = 0; act[m] = 1'b0; sent[m] = 1'b0;
    end
    s_aw_ready = 1'b1;
    s_w_ready  = 1'b1;
    for (int cyc = 0; cyc < 100 && nw < 16; cyc++) begin
      for (int m = 0; m < 2; m++) begin
        if (!act[m] && left[m] > 0) begin
          act[m] = 1'b1; sent[m] = 1'b0; beat[m] = 0;
        end
        m_aw_valid[m] = act[m] && !sent[m];
        m_aw_pld[m*38 +: 38] = awp(8'(m*16 + nb[m]), 8'd3);
        m_w_valid[m] = act[m] && (beat[m] < 4);
        m_w_last[m]  = (beat[m] == 3);
        m_w_pld[m*10 +: 10] = wp(8'(m*16 + nb[m]*4 + beat[m]));
      end
      #1;
      if (s_aw_valid && s_aw_ready) begin
        check_eq("t2_aw", {s_aw_id, s_aw_pld[37:30]},
                 {((naw % 2) == 1) ? 2'b11 : 2'b00, 8'((naw % 2)*16 + naw/2)});
        naw++;
      end
      if (s_w_valid && s_w_ready) begin
        k = nw / 4;
        check_eq("t2_w", {s_w_last, s_w_pld[9:2]},
                 {((nw % 4) == 3), 8'((k % 2)*16 + (k/2)*4 + nw % 4)});
        nw++;
      end
      for (int m = 0; m < 2; m++) begin
        if (m_aw_valid[m] && m_aw_ready[m]) sent[m] = 1'b1;
        if (m_w_valid[m] && m_w_ready[m]) beat[m]++;
        if (act[m] && sent[m] && beat[m] == 4) begin
          act[m] = 1'b0; left[m]--; nb[m]++;
        end
      end
      @(negedge clk);
    end
    check_eq("t2_count", {32'(naw), 32'(nw)}, {32'd4, 32'd16});
    clear_inputs();
  endtask

  initial begin
    clear_inputs();

    // 1) reset with every master requesting
    m_aw_valid = 2'b11; m_w_valid = 2'b11; m_w_last = 2'b11;
    s_aw_ready = 1'b1; s_w_ready = 1'b1;
    @(negedge clk); #1;
    check_eq("t1_s_valid", {s_aw_valid, s_w_valid}, 2'b00);
    check_eq("t1_m_ready", {m_aw_ready, m_w_ready}, 4'b0000);
    @(negedge clk);
    rst = 1'b0; #1;
    check_eq("t1_idle", {s_aw_valid, m_aw_ready}, 3'b000);
    @(negedge clk); #1;
    check_eq("t1_grant0", {s_aw_valid, s_aw_id[1], m_aw_ready}, 4'b1001);

    // 2) alternating grants, no W interleaving
    do_reset();
    run_alt();

    // 3) W ahead of AW on master 1, slave holds AW off
    do_reset();
    m_w_valid = 2'b10; m_w_pld[19:10] = wp(8'h20); s_w_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1 check_eq("t3_wstall", {s_w_valid, m_w_ready}, 3'b000);
      @(negedge clk);
    end
    m_aw_valid = 2'b10; m_aw_pld[75:38] = awp(8'hA1, 8'd3);
    #1 check_eq("t3_arb", {s_aw_valid, m_aw_ready}, 3'b000);
    @(negedge clk);
    for (int j = 0; j < 4; j++) begin
      m_w_pld[19:10] = wp(8'(8'h20 + j));
      m_w_last = (j == 3) ? 2'b10 : 2'b00;
      #1 check_eq("t3_wbeat", {s_aw_valid, s_w_valid, m_w_ready, s_w_last, s_w_pld[9:2]},
                  {1'b1, 1'b1, 2'b10, (j == 3), 8'(8'h20 + j)});
      @(negedge clk);
    end
    m_w_valid = 2'b00; m_w_last = 2'b00;
    #1 check_eq("t3_wdone", {s_aw_valid, s_w_valid, m_aw_ready, m_w_ready}, 6'b100000);
    @(negedge clk);
    s_aw_ready = 1'b1;
    #1 check_eq("t3_awhs", {s_aw_valid, m_aw_ready, s_aw_id, s_aw_pld[37:30]},
                {1'b1, 2'b10, 2'b11, 8'hA1});
    @(negedge clk);

    // 4) len=0 with AW and W(last) in the same cycle, master 1 waiting
    m_aw_valid = 2'b11;
    m_aw_pld[37:0] = awp(8'h05, 8'd0); m_aw_pld[75:38] = awp(8'hB2, 8'd0);
    m_w_valid = 2'b01; m_w_last = 2'b01; m_w_pld[9:0] = wp(8'h55);
    #1 check_eq("t3_back_idle", {s_aw_valid, s_w_valid, m_aw_ready, m_w_ready}, 6'b000000);
    @(negedge clk); #1;
    check_eq("t4_busy", {s_aw_valid, s_w_valid, s_w_last, m_aw_ready, m_w_ready, s_aw_id},
             {1'b1, 1'b1, 1'b1, 2'b01, 2'b01, 2'b00});
    check_eq("t4_wdata", s_w_pld[9:2], 8'h55);
    @(negedge clk);
    m_aw_valid = 2'b10; m_w_valid = 2'b00; m_w_last = 2'b00;
    #1 check_eq("t4_idle", {s_aw_valid, m_aw_ready}, 3'b000);
    @(negedge clk); #1;
    check_eq("t4_next", {s_aw_valid, s_aw_id, m_aw_ready, s_aw_pld[37:30]},
             {1'b1, 2'b11, 2'b10, 8'hB2});

    // 5) B routing by ID prefix
    do_reset();
    s_b_id = 2'b11; s_b_resp = 2'b10; s_b_user = 1'b1; s_b_valid = 1'b1; m_b_ready = 2'b00;
    for (int i = 0; i < 3; i++) begin
      #1 check_eq("t5_b_hold", {m_b_valid, s_b_ready, m_b_id}, {2'b10, 1'b0, 2'b11});
      @(negedge clk);
    end
    m_b_ready = 2'b10;
    #1 check_eq("t5_b_go", {m_b_valid, s_b_ready, m_b_resp, m_b_user},
                {2'b10, 1'b1, 4'b1010, 2'b11});
    s_b_id = 2'b00; m_b_ready = 2'b10;
    #1 check_eq("t5_b0_wrong_ready", {m_b_valid, s_b_ready, m_b_id}, {2'b01, 1'b0, 2'b00});
    m_b_ready = 2'b01;
    #1 check_eq("t5_b0_ready", {m_b_valid, s_b_ready}, {2'b01, 1'b1});
    s_b_valid = 1'b0;
    #1 check_eq("t5_b_none", m_b_valid, 2'b00);
    @(negedge clk);

    // 6) reset in the middle of a master-1 burst
    do_reset();
    m_aw_valid = 2'b10; m_aw_pld[75:38] = awp(8'hC3, 8'd3);
    m_w_valid = 2'b10; m_w_pld[19:10] = wp(8'h40);
    s_aw_ready = 1'b1; s_w_ready = 1'b1;
    @(negedge clk); #1;
    check_eq("t6_beat0", {s_aw_valid, s_w_valid, m_w_ready}, 4'b1110);
    @(negedge clk);
    m_aw_valid = 2'b00; m_w_pld[19:10] = wp(8'h41);
    #1 check_eq("t6_beat1", {s_w_valid, s_w_pld[9:2]}, {1'b1, 8'h41});
    @(negedge clk);
    m_w_pld[19:10] = wp(8'h42); m_aw_valid = 2'b11;
    rst = 1'b1;
    #1 check_eq("t6_rst", {s_aw_valid, s_w_valid, m_aw_ready, m_w_ready}, 6'b000000);
    @(negedge clk);
    rst = 1'b0; m_w_valid = 2'b00;
    #1 check_eq("t6_idle", {s_aw_valid, m_aw_ready}, 3'b000);
    @(negedge clk); #1;
    check_eq("t6_restart", {s_aw_valid, s_aw_id[1], m_aw_ready}, 4'b1001);

    clear_inputs();
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
